// File: rtl/median_blur_pkg.sv
// median_blur_pkg: shared types and constants for the 3x3 median stream controller.
// Holds width defaults, the sequencer state enum and window index constants.
package median_blur_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_MAX_W  = 640;

  localparam int WIN_N     = 9;
  localparam int WIN_ROW   = 3;
  localparam int PX_CENTRE = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

endpackage

// File: rtl/median_line_buffer.sv
// median_line_buffer: one raster line of pixels, addressed by column.
// Ports: clk, en (write strobe), addr (column), wdata, rdata (old value, read-before-write).
module median_line_buffer
  import median_blur_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_MAX_W,
  parameter int A_BITS = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [A_BITS-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Combinational read returns the value stored before this cycle's write.
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/median_blur_stream_ctrl.sv
// median_blur_stream_ctrl: frame sequencer feeding an external 3x3 median network.
// Build option: MEDIAN_CTRL_BYPASS_EN adds the bypass port (out_data = window centre).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, cfg_width/height   frame request and geometry (W>=3, W<=MAX_W, H>=3)
//   busy, done, cfg_err   frame status; done/cfg_err are one-cycle pulses
//   in_valid/in_data/in_ready   raster pixel input stream
//   win_px, med_in        window to the median core and its result
//   out_valid/out_data/out_last/out_ready   (W-2)x(H-2) valid-region output stream
module median_blur_stream_ctrl
  import median_blur_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int MAX_W  = DEF_MAX_W,
  parameter int W_BITS = 10,
  parameter int H_BITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [W_BITS-1:0]     cfg_width,
  input  logic [H_BITS-1:0]     cfg_height,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic [9*DATA_W-1:0]   win_px,
  input  logic [DATA_W-1:0]     med_in,
`ifdef MEDIAN_CTRL_BYPASS_EN
  input  logic                  bypass,
`endif
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  input  logic                  out_ready
);

  localparam logic [W_BITS-1:0] W_MIN = W_BITS'(3);
  localparam logic [W_BITS-1:0] W_MAX = W_BITS'(MAX_W);
  localparam logic [H_BITS-1:0] H_MIN = H_BITS'(3);
  localparam logic [W_BITS-1:0] C_TWO = W_BITS'(2);
  localparam logic [H_BITS-1:0] R_TWO = H_BITS'(2);

  state_e state;
  state_e state_nx;

  logic [W_BITS-1:0] col;
  logic [W_BITS-1:0] w_last;
  logic [H_BITS-1:0] row;
  logic [H_BITS-1:0] h_last;

  logic [DATA_W-1:0] win [WIN_N];
  logic [DATA_W-1:0] lb0_q;
  logic [DATA_W-1:0] lb1_q;

  logic cfg_bad;
  logic go;
  logic accept;
  logic hs;
  logic col_end;
  logic at_end;
  logic qual;

  assign cfg_bad = (cfg_width < W_MIN)
                 || (cfg_width > W_MAX)
                 || (cfg_height < H_MIN);

  assign go      = (state == IDLE) && start && !cfg_bad;
  assign busy    = (state != IDLE);

  // A stalled output holds in_ready low, which freezes the window
  // so med_in stays stable until the handshake completes.
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign hs       = out_valid && out_ready;

  assign col_end = (col == w_last);
  assign at_end  = col_end && (row == h_last);
  assign qual    = (row >= R_TWO) && (col >= C_TWO);

  median_line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_W),
    .A_BITS (W_BITS)
  ) u_lb0 (
    .clk   (clk),
    .en    (accept),
    .addr  (col),
    .wdata (in_data),
    .rdata (lb0_q)
  );

  median_line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_W),
    .A_BITS (W_BITS)
  ) u_lb1 (
    .clk   (clk),
    .en    (accept),
    .addr  (col),
    .wdata (lb0_q),
    .rdata (lb1_q)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (go) state_nx = RUN;
      RUN:     if (accept && at_end) state_nx = DRAIN;
      DRAIN:   if (hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      done    <= (state == DRAIN) && hs;
      cfg_err <= (state == IDLE) && start && cfg_bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col    <= '0;
      row    <= '0;
      w_last <= '0;
      h_last <= '0;
    end else if (go) begin
      col    <= '0;
      row    <= '0;
      w_last <= cfg_width - W_BITS'(1);
      h_last <= cfg_height - H_BITS'(1);
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= row + H_BITS'(1);
      end else begin
        col <= col + W_BITS'(1);
      end
    end
  end

  // Columns shift left; the new right column comes from
  // two lines up, one line up and the incoming pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_N; i++) begin
        win[i] <= '0;
      end
    end else if (accept) begin
      for (int r = 0; r < WIN_ROW; r++) begin
        win[r*WIN_ROW]   <= win[r*WIN_ROW+1];
        win[r*WIN_ROW+1] <= win[r*WIN_ROW+2];
      end
      win[2] <= lb1_q;
      win[5] <= lb0_q;
      win[8] <= in_data;
    end
  end

  // An accept implies any pending output was taken this cycle,
  // so out_valid simply follows whether the new window qualifies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= qual;
      out_last  <= qual && at_end;
    end else if (hs) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  for (genvar k = 0; k < WIN_N; k++) begin : g_win
    assign win_px[k*DATA_W +: DATA_W] = win[k];
  end

`ifdef MEDIAN_CTRL_BYPASS_EN
  assign out_data = bypass ? win[PX_CENTRE] : med_in;
`else
  assign out_data = med_in;
`endif

endmodule

// File: tb/tb_median_blur_stream_ctrl.sv
// tb_median_blur_stream_ctrl: directed frames against the median stream controller.
// Supplies a behavioural median network on med_in and checks hand-computed outputs.
module tb_median_blur_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  cfg_width = '0;
  logic [9:0]  cfg_height = '0;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic [71:0] win_px;
  logic [7:0]  med_in;
`ifdef MEDIAN_CTRL_BYPASS_EN
  logic        bypass = 1'b0;
`endif
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_cyc = 0;
  int stall_cnt = 0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  bit toggle = 1'b0;
  int pi = 0;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  logic [7:0]  oq [$];
  bit          lq [$];
  logic [71:0] wq [$];

  logic [7:0] pix [64];
  logic [7:0] expv [16];
  logic [7:0] t3 [9] = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
  logic [7:0] e5 [9] = '{8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13, 8'd16, 8'd17, 8'd18};
  logic [7:0] e64 [8] = '{8'd7, 8'd8, 8'd9, 8'd10, 8'd13, 8'd14, 8'd15, 8'd16};

  median_blur_stream_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .win_px     (win_px),
    .med_in     (med_in),
`ifdef MEDIAN_CTRL_BYPASS_EN
    .bypass     (bypass),
`endif
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] med9(input logic [71:0] w);
    logic [7:0] a [9];
    logic [7:0] t;
    for (int i = 0; i < 9; i++) a[i] = w[i*8 +: 8];
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 8 - i; j++) begin
        if (a[j] > a[j+1]) begin
          t = a[j];
          a[j] = a[j+1];
          a[j+1] = t;
        end
      end
    end
    return a[4];
  endfunction

  assign med_in = med9(win_px);

  task automatic chk(input string tag, input logic [71:0] got,
                     input logic [71:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle) begin
        out_ready = pat[pi];
        pi = (pi + 1) % 4;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      oq.push_back(out_data);
      lq.push_back(out_last);
      wq.push_back(win_px);
      if (out_last) last_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (out_valid && !out_ready) begin
      stall_cnt++;
      chk("stall_in_ready", {71'd0, in_ready}, 72'd0);
    end
    if (out_valid && prev_stall) begin
      chk("stall_hold", {64'd0, out_data}, {64'd0, prev_data});
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
  end

  task automatic start_frame(input int w, input int h);
    cfg_width  = 10'(w);
    cfg_height = 10'(h);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("push_timeout", 72'd0, 72'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_seen", {71'd0, done_cnt != d0}, 72'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", 72'(done_cnt - d0), 72'd1);
    chk("done_lat", 72'(done_cyc - last_cyc), 72'd1);
    chk("busy_idle", {71'd0, busy}, 72'd0);
  endtask

  task automatic run_frame(input int w, input int h);
    int d0;
    d0 = done_cnt;
    oq.delete();
    lq.delete();
    wq.delete();
    start_frame(w, h);
    for (int i = 0; i < w * h; i++) push(pix[i]);
    wait_done(d0);
  endtask

  task automatic check_outs(input string nm, input int n);
    chk({nm, "_count"}, 72'(oq.size()), 72'(n));
    for (int i = 0; i < n && i < oq.size(); i++) begin
      chk($sformatf("%s_data%0d", nm, i), {64'd0, oq[i]}, {64'd0, expv[i]});
      chk($sformatf("%s_last%0d", nm, i), {71'd0, lq[i]}, {71'd0, i == n - 1});
    end
  endtask

  task automatic load_ramp(input int n);
    for (int i = 0; i < n; i++) pix[i] = 8'(i);
  endtask

  task automatic bad_cfg(input string nm, input int w, input int h);
    start_frame(w, h);
    chk({nm, "_err"}, {71'd0, cfg_err}, 72'd1);
    chk({nm, "_busy"}, {71'd0, busy}, 72'd0);
    chk({nm, "_rdy"}, {71'd0, in_ready}, 72'd0);
    @(posedge clk);
    #1;
    chk({nm, "_pulse"}, {71'd0, cfg_err}, 72'd0);
    chk({nm, "_busy2"}, {71'd0, busy}, 72'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {71'd0, busy}, 72'd0);
    chk("rst_valid", {71'd0, out_valid}, 72'd0);
    chk("rst_rdy", {71'd0, in_ready}, 72'd0);
    chk("rst_win", win_px, 72'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    load_ramp(25);
    for (int i = 0; i < 9; i++) expv[i] = e5[i];
    run_frame(5, 5);
    check_outs("f5", 9);

    for (int i = 0; i < 9; i++) pix[i] = t3[i];
    expv[0] = 8'd5;
    run_frame(3, 3);
    check_outs("f3", 1);
    if (wq.size() > 0) begin
      chk("f3_win", wq[0],
          {8'd5, 8'd4, 8'd6, 8'd3, 8'd7, 8'd2, 8'd8, 8'd1, 8'd9});
    end

    load_ramp(24);
    for (int i = 0; i < 8; i++) expv[i] = e64[i];
    stall_cnt = 0;
    pi = 0;
    toggle = 1'b1;
    run_frame(6, 4);
    toggle = 1'b0;
    check_outs("f64", 8);
    chk("f64_stalls", {71'd0, stall_cnt > 0}, 72'd1);

    bad_cfg("w2", 2, 5);
    bad_cfg("w641", 641, 5);
    bad_cfg("h2", 5, 2);

    load_ramp(64);
    begin
      int d0;
      d0 = done_cnt;
      start_frame(8, 8);
      for (int i = 0; i < 20; i++) push(pix[i]);
      chk("pre_rst_valid", {71'd0, out_valid}, 72'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", {71'd0, busy}, 72'd0);
      chk("arst_valid", {71'd0, out_valid}, 72'd0);
      chk("arst_last", {71'd0, out_last}, 72'd0);
      chk("arst_rdy", {71'd0, in_ready}, 72'd0);
      chk("arst_done", {71'd0, done}, 72'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("arst_nodone", 72'(done_cnt - d0), 72'd0);
    end

    load_ramp(25);
    for (int i = 0; i < 9; i++) expv[i] = e5[i];
    run_frame(5, 5);
    check_outs("f5b", 9);

`ifdef MEDIAN_CTRL_BYPASS_EN
    bypass = 1'b1;
    run_frame(5, 5);
    check_outs("byp5", 9);
    for (int i = 0; i < 9; i++) pix[i] = t3[i];
    expv[0] = 8'd7;
    run_frame(3, 3);
    check_outs("byp3", 1);
    bypass = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/median_blur_stream_ctrl.md
Name: median_blur_stream_ctrl

Overview:
Frame sequencer for the combinational 3x3 median network (36 compare-exchange PEs, 9 inputs px_1..px_9, one median output). Accepts a raster pixel stream and keeps two line buffers plus a 3x3 window register. Presents each complete window to the external median instance and returns its result on a valid/ready output stream. Output is the valid-region image of (W-2) x (H-2) pixels; no border padding.

Parameters:
DATA_W, 8, pixel width; must match the median network width.
MAX_W, 640, maximum line width; sets line-buffer depth.
W_BITS, 10, width of the column counter and cfg_width.
H_BITS, 10, width of the row counter and cfg_height.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to begin a frame; samples cfg_*.
cfg_width  input  W_BITS  frame width W; legal range 3..MAX_W.
cfg_height  input  H_BITS  frame height H; legal range >=3.
busy  output  1  high from accepted start until done.
done  output  1  one-cycle pulse after the final output handshake.
cfg_err  output  1  one-cycle pulse when start is rejected for illegal config.
in_valid  input  1  input pixel valid.
in_data  input  DATA_W  input pixel, raster order.
in_ready  output  1  input pixel accepted when in_valid && in_ready.
win_px  output  9*DATA_W  window to the median core; slice k-1 = px_k; px_1..px_3 top row left->right, px_7..px_9 bottom row.
med_in  input  DATA_W  median result from the core, combinational from win_px.
bypass  input  1  present only with the optional feature.
out_valid  output  1  output pixel valid.
out_data  output  DATA_W  output pixel (driven from med_in).
out_last  output  1  marks the final output pixel of the frame.
out_ready  input  1  downstream accept.

Behaviour:
- Reset values: state IDLE; busy, done, cfg_err, in_ready, out_valid, out_last = 0; counters and window registers = 0. Line-buffer contents are don't-care.
- FSM states:
  - IDLE:
    - start with legal cfg: latch W and H, clear counters, go RUN.
    - start with W<3, W>MAX_W, or H<3: pulse cfg_err next cycle, stay IDLE.
  - RUN: on each accept, update the window and line buffers and advance (col,row) in raster order. After accepting (row H-1, col W-1), go DRAIN.
  - DRAIN: wait for the final out handshake. Then pulse done, go IDLE.
- start while busy is ignored; no error pulse.
- in_ready = (state==RUN) && (!out_valid || out_ready). A stalled output freezes the window, so med_in stays stable.
- On accept at (r,c):
  - Window columns shift left; the new right column is {linebuf1[c], linebuf0[c], in_data}, top to bottom.
  - linebuf1[c] <= linebuf0[c]; linebuf0[c] <= in_data.
- Output:
  - An accept with r>=2 and c>=2 sets out_valid at the next edge (latency 1 cycle). The window then ends at (r,c).
  - An accept with r<2 or c<2 produces no output; out_valid clears if its handshake completed.
- out_last is set together with out_valid for the accept at (H-1,W-1) and clears on that handshake.
- Total outputs per frame = (W-2)*(H-2). Example: W=4, H=3 gives 2.
- Column wrap: at c==W-1, col<=0 and row++. Window columns from the previous line are overwritten before the next output (c>=2), so no clearing is needed.
- Simultaneous out handshake and new qualifying accept: out_valid stays 1 and out_data reflects the new window.
- Async reset mid-frame aborts the frame: no done and no out_last. The next start begins a clean frame.

Optional Feature:
MEDIAN_CTRL_BYPASS_EN
- Defined: the bypass port exists, sampled per output. When 1, out_data = window centre px_5 instead of med_in, with identical timing and handshake.
- Undefined: no bypass port; out_data = med_in always.

Decomposition:
- Package median_blur_pkg holds:
  - DATA_W and MAX_W defaults.
  - State enum: IDLE, RUN, DRAIN.
  - Window index constants: PX_CENTRE = 4 (px_5).
- Sub-module median_line_buffer: single-port-style MAX_W x DATA_W array, read/write at the same address per accept, read-before-write. Instantiated twice.

Test Plan:
- Frame 5x5, pixels 0..24 raster, out_ready=1 -> 9 outputs 6,7,8,11,12,13,16,17,18; out_last on the 9th; done one cycle after.
- Frame 3x3, values {9,1,8,2,7,3,6,4,5} -> single output 5 with out_last=1; exactly one done pulse.
- Frame 6x4 with out_ready toggling 1,0,0,1 -> in_ready low during stalls, out_data stable while stalled, 8 outputs, none lost or duplicated.
- start with cfg_width=2 (and separately 641) -> cfg_err pulse, busy stays 0, in_ready stays 0.
- rst_n low for 1 cycle mid-frame of 8x8 -> all outputs 0 immediately; a fresh 5x5 frame then matches the first scenario.
- With MEDIAN_CTRL_BYPASS_EN and bypass=1 on a 5x5 ramp -> outputs equal the window centres 6,7,8,11,12,13,16,17,18.
